// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_pkg
//  Description : Shared width default and FSM encoding for the E-stage divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

    localparam int c_DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } divState_t;

endpackage
`default_nettype wire

// File: rtl/div_unit_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_step
//  Description : One restoring-division bit: shift {rem, quo} left, trial-subtract.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    // One extra bit so the shifted remainder never overflows and the borrow is visible.
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_shifted = {i_rem, i_quo[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, i_div};
        if (w_diff[WIDTH]) begin
            o_rem = w_shifted[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end else begin
            o_rem = w_diff[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative radix-2 restoring divider (DIV/DIVU) with E-stage stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = c_DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             annul,
    input  logic             hold,
    output logic             stall_div,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                 c_CNT_W     = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    divState_t          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic               r_signQ;
    logic               r_signR;

    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [WIDTH-1:0]   w_stepRem;
    logic [WIDTH-1:0]   w_stepQuo;
    logic [WIDTH-1:0]   w_quoFix;
    logic [WIDTH-1:0]   w_remFix;

    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_stepRem),
        .o_quo (w_stepQuo)
    );

    // Fix-up works on the final step's outputs so hi/lo land exactly on entry to DONE.
    always_comb begin
        w_absA    = (signed_div && opa[WIDTH-1]) ? -opa : opa;
        w_absB    = (signed_div && opb[WIDTH-1]) ? -opb : opb;
        w_quoFix  = r_signQ ? -w_stepQuo : w_stepQuo;
        w_remFix  = r_signR ? -w_stepRem : w_stepRem;
        stall_div = start && !annul && (r_state != S_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_signQ <= 1'b0;
            r_signR <= 1'b0;
            ready   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (annul) begin
            r_state <= S_IDLE;
            ready   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_signQ <= signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        r_signR <= signed_div && opa[WIDTH-1];
                        r_quo   <= w_absA;
                        r_div   <= w_absB;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        if (opb == '0) begin
                            lo      <= '1;
                            hi      <= opa;
                            ready   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_rem <= w_stepRem;
                    r_quo <= w_stepQuo;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_LAST_STEP) begin
                        lo      <= w_quoFix;
                        hi      <= w_remFix;
                        ready   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!hold) begin
                        ready   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    ready   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Directed scoreboard bench for div_unit (timing, signs, hold, annul, reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        annul;
    logic        hold;
    logic        stall_div;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [63:0] expQ[$];
    logic        prevReady = 1'b0;
    logic [31:0] curLo = '0;
    logic [31:0] curHi = '0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .annul      (annul),
        .hold       (hold),
        .stall_div  (stall_div),
        .ready      (ready),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops one expected {lo,hi} per ready rising edge, then demands stability.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (ready && !prevReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: lo=0x%08h hi=0x%08h with no op pending", lo, hi);
                end else begin
                    e = expQ.pop_front();
                    if ({lo, hi} !== e) begin
                        errors++;
                        $display("FAIL result: lo=0x%08h hi=0x%08h expected lo=0x%08h hi=0x%08h",
                                 lo, hi, e[63:32], e[31:0]);
                    end
                    curLo = e[63:32];
                    curHi = e[31:0];
                end
            end else if (ready && prevReady) begin
                checks++;
                if (lo !== curLo || hi !== curHi) begin
                    errors++;
                    $display("FAIL stable: lo=0x%08h hi=0x%08h expected lo=0x%08h hi=0x%08h",
                             lo, hi, curLo, curHi);
                end
            end
            prevReady = ready;
        end
    end

    task automatic runOp(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eLo, input logic [31:0] eHi, input int holdN,
                         input int eStall, input int eReadyCyc);
        int cyc, stallCnt, readyCyc, readyLen, stallDone;
        expQ.push_back({eLo, eHi});
        @(posedge clk); #1;
        signed_div = sgn; opa = a; opb = b; start = 1'b1; hold = 1'b0;
        cyc = 0; stallCnt = 0; readyCyc = -1; readyLen = 0; stallDone = 0;
        while (readyCyc < 0 && cyc < 100) begin
            @(negedge clk);
            if (stall_div) stallCnt++;
            if (ready) readyCyc = cyc;
            else begin
                @(posedge clk); #1;
                opa = ~a; opb = ~b;  // operands must be ignored after accept
                cyc++;
            end
        end
        check({name, "_stall_cycles"}, stallCnt, eStall);
        check({name, "_ready_cycle"}, readyCyc, eReadyCyc);
        if (readyCyc >= 0) begin
            for (int k = 0; k <= holdN; k++) begin
                hold = (k < holdN);
                if (ready) readyLen++;
                if (stall_div) stallDone++;
                @(posedge clk); #1;
                if (k < holdN) @(negedge clk);
            end
            check({name, "_ready_len"}, readyLen, holdN + 1);
            check({name, "_stall_in_done"}, stallDone, 0);
        end
        start = 1'b0; hold = 1'b0;
        @(negedge clk);
        check({name, "_ready_after"}, {31'd0, ready}, 32'd0);
    endtask

    initial begin
        int seen;
        resetn = 1'b0; start = 1'b0; signed_div = 1'b0; opa = '0; opb = '0;
        annul = 1'b0; hold = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_stall", {31'd0, stall_div}, 32'd0);
        resetn = 1'b1;

        runOp("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 33, 33);
        runOp("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 33, 33);
        runOp("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 33, 33);
        runOp("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, 33, 33);
        runOp("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 33, 33);
        runOp("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0, 1, 1);
        runOp("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0, 1, 1);
        runOp("divu_9_4_hold", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 3, 33, 33);

        // Annul at cycle 10 of a 1000/3 divide: no result may ever appear.
        @(posedge clk); #1;
        signed_div = 1'b0; opa = 32'd1000; opb = 32'd3; start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        annul = 1'b1;
        @(negedge clk);
        check("annul_stall", {31'd0, stall_div}, 32'd0);
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen++;
        end
        check("annul_no_ready", seen, 0);

        // Reset at cycle 15 of a busy divide: everything clears immediately.
        runOp("divu_pre_rst", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 0, 33, 33);
        @(posedge clk); #1;
        signed_div = 1'b0; opa = 32'd77; opb = 32'd5; start = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        resetn = 1'b0; start = 1'b0;
        #1;
        check("arst_ready", {31'd0, ready}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_stall", {31'd0, stall_div}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        runOp("divu_after_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 33, 33);

        repeat (3) @(negedge clk);
        check("queue_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
